// File: rtl/sysreg_pkg.sv
// sysreg_pkg: shared constants for the system register bank.
// Register offsets are the decoded a[4:0] values; STATUS bit positions,
// the OVF-clear write bit and the value returned for unmapped reads.
package sysreg_pkg;

   localparam logic [4:0] REG_ID0           = 5'h00;
   localparam logic [4:0] REG_ID1           = 5'h01;
   localparam logic [4:0] REG_VERSION       = 5'h02;
   localparam logic [4:0] REG_STATUS        = 5'h03;
   localparam logic [4:0] REG_LW_ADDR       = 5'h04;
   localparam logic [4:0] REG_LW_DATA       = 5'h05;
   localparam logic [4:0] REG_HIST_COUNT    = 5'h06;
   localparam logic [4:0] REG_HIST_ADDR     = 5'h07;
   localparam logic [4:0] REG_HIST_DATA     = 5'h08;
   localparam logic [4:0] REG_CNT0          = 5'h0C;
   localparam logic [4:0] REG_CNT1          = 5'h0D;
   localparam logic [4:0] REG_CNT2          = 5'h0E;
   localparam logic [4:0] REG_CNT3          = 5'h0F;

   localparam int STAT_OVF_BIT   = 7;
   localparam int STAT_EMPTY_BIT = 6;
   localparam int STAT_FULL_BIT  = 5;
   localparam int OVF_CLR_BIT    = 7;

   localparam logic [7:0] UNMAPPED_VAL   = 8'hFF;
   localparam logic [7:0] EMPTY_READ_VAL = 8'h00;

endpackage

// File: rtl/sysreg_hist_fifo.sv
// sysreg_hist_fifo: synchronous first-word-fall-through FIFO holding the
// write history. Flush has priority over push/pop; a pop on empty is ignored;
// a push while full is accepted only when a pop frees a slot in the same cycle.
module sysreg_hist_fifo
   import sysreg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_r == CNT_W'(DEPTH));
   assign empty = (count_r == {CNT_W{1'b0}});
   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

   // Qualify requests: pop needs data, push needs room or a simultaneous pop.
   always_comb begin
      do_pop_s  = 1'b0;
      do_push_s = 1'b0;
      if (pop && !empty) begin
         do_pop_s = 1'b1;
      end else begin
         do_pop_s = 1'b0;
      end
      if (push && (!full || do_pop_s)) begin
         do_push_s = 1'b1;
      end else begin
         do_push_s = 1'b0;
      end
   end

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally at power-of-2 depth.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/sysreg_bank.sv
// sysreg_bank: host-bus system register bank (ID/version, scratch bytes,
// last-write capture, write-history FIFO) with one registered read port.
// Optional feature macro: SYSREG_CYCLE_COUNTER_EN adds a 32-bit free-running
// cycle counter readable coherently at 0x0C..0x0F (reading 0x0C snapshots
// the upper three bytes). Without it 0x0C..0x0F read as unmapped.
module sysreg_bank
   import sysreg_pkg::*;
#(
   parameter int          ADDR_W     = 8,
   parameter int          NSCRATCH   = 4,
   parameter int          HIST_DEPTH = 8,
   parameter logic [7:0]  ID0        = 8'h42,
   parameter logic [7:0]  ID1        = 8'h73,
   parameter logic [7:0]  VERSION    = 8'h02
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] a,
   input  logic [7:0]        d_d,
   output logic [7:0]        d_q,
   input  logic              read_strobe,
   input  logic              write_strobe
);

   localparam int CNT_W  = $clog2(HIST_DEPTH) + 1;
   localparam int SIDX_W = (NSCRATCH > 1) ? $clog2(NSCRATCH) : 1;

   logic [4:0]        off_s;
   logic              scr_hit_s;
   logic [SIDX_W-1:0] scr_idx_s;
   logic [7:0]        scratch_r [NSCRATCH];
   logic [7:0]        lw_addr_r;
   logic [7:0]        lw_data_r;
   logic              ovf_r;
   logic [7:0]        d_q_r;
   logic [7:0]        rd_val_s;
   logic [7:0]        status_s;
   logic [7:0]        hist_cnt8_s;
   logic              push_s;
   logic              pop_s;
   logic              flush_s;
   logic              ovf_clr_s;
   logic              ovf_set_s;
   logic [15:0]       fifo_head_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;

   // Only a[4:0] is decoded; higher bits alias.
   assign off_s     = a[4:0];
   assign scr_hit_s = off_s[4] && ({1'b0, off_s[3:0]} < 5'(NSCRATCH));
   assign scr_idx_s = off_s[SIDX_W-1:0];

   generate
      if (ADDR_W > 8) begin : g_addr_hi
         logic unused_addr_hi_s;
         assign unused_addr_hi_s = ^a[ADDR_W-1:8];
      end
   endgenerate

   // Bus-strobe decode into FIFO controls and OVF set/clear events.
   always_comb begin
      push_s    = write_strobe && (off_s != REG_STATUS) && (off_s != REG_HIST_COUNT);
      flush_s   = write_strobe && (off_s == REG_HIST_COUNT);
      pop_s     = read_strobe && (off_s == REG_HIST_DATA);
      ovf_clr_s = write_strobe && (off_s == REG_STATUS) && d_d[OVF_CLR_BIT];
      ovf_set_s = push_s && fifo_full_s && !pop_s;
   end

   sysreg_hist_fifo #(
      .WIDTH (16),
      .DEPTH (HIST_DEPTH)
   ) u_hist_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_s),
      .pop     (pop_s),
      .flush   (flush_s),
      .wr_data ({a[7:0], d_d}),
      .head    (fifo_head_s),
      .count   (fifo_count_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Assemble STATUS and the zero-extended history count.
   always_comb begin
      status_s                 = 8'h00;
      status_s[STAT_OVF_BIT]   = ovf_r;
      status_s[STAT_EMPTY_BIT] = fifo_empty_s;
      status_s[STAT_FULL_BIT]  = fifo_full_s;
      hist_cnt8_s              = 8'h00;
      hist_cnt8_s[CNT_W-1:0]   = fifo_count_s;
   end

`ifdef SYSREG_CYCLE_COUNTER_EN
   logic [31:0] cyc_cnt_r;
   logic [23:0] cyc_snap_r;

   // Free-running counter; reading the low byte freezes the upper bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt_r  <= 32'h0000_0000;
         cyc_snap_r <= 24'h00_0000;
      end else begin
         cyc_cnt_r <= cyc_cnt_r + 32'd1;
         if (read_strobe && (off_s == REG_CNT0)) begin
            cyc_snap_r <= cyc_cnt_r[31:8];
         end
      end
   end
`endif

   // Read mux: selects the pre-write value of the addressed register.
   always_comb begin
      rd_val_s = UNMAPPED_VAL;
      if (scr_hit_s) begin
         rd_val_s = scratch_r[scr_idx_s];
      end else begin
         case (off_s)
            REG_ID0:        rd_val_s = ID0;
            REG_ID1:        rd_val_s = ID1;
            REG_VERSION:    rd_val_s = VERSION;
            REG_STATUS:     rd_val_s = status_s;
            REG_LW_ADDR:    rd_val_s = lw_addr_r;
            REG_LW_DATA:    rd_val_s = lw_data_r;
            REG_HIST_COUNT: rd_val_s = hist_cnt8_s;
            REG_HIST_ADDR:  rd_val_s = fifo_empty_s ? EMPTY_READ_VAL : fifo_head_s[15:8];
            REG_HIST_DATA:  rd_val_s = fifo_empty_s ? EMPTY_READ_VAL : fifo_head_s[7:0];
`ifdef SYSREG_CYCLE_COUNTER_EN
            REG_CNT0:       rd_val_s = cyc_cnt_r[7:0];
            REG_CNT1:       rd_val_s = cyc_snap_r[7:0];
            REG_CNT2:       rd_val_s = cyc_snap_r[15:8];
            REG_CNT3:       rd_val_s = cyc_snap_r[23:16];
`endif
            default:        rd_val_s = UNMAPPED_VAL;
         endcase
      end
   end

   // Registered read data; holds between read strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q_r <= 8'h00;
      end else if (read_strobe) begin
         d_q_r <= rd_val_s;
      end
   end

   assign d_q = d_q_r;

   // Scratch storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSCRATCH; i++) begin
            scratch_r[i] <= 8'h00;
         end
      end else if (write_strobe && scr_hit_s) begin
         scratch_r[scr_idx_s] <= d_d;
      end
   end

   // Last-write capture on every write strobe, whatever the target.
   always_ff @(posedge clk) begin
      if (rst) begin
         lw_addr_r <= 8'h00;
         lw_data_r <= 8'h00;
      end else if (write_strobe) begin
         lw_addr_r <= a[7:0];
         lw_data_r <= d_d;
      end
   end

   // Sticky overflow flag; an explicit clear wins over a new overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (ovf_clr_s) begin
         ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
         ovf_r <= 1'b1;
      end
   end

endmodule
